// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick-driven interval timer: FSM encoding and default counter width.
package tick_timer_pkg;

    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tick_timer.sv
// Programmable down-counting interval timer clocked by an external tick enable.
// Define AUTO_RELOAD_EN for periodic operation; the default build is one-shot.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         tick,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] load_val,
    input  logic         irq_clr,
    output logic         busy,
    output logic [W-1:0] cnt,
    output logic         done,
    output logic         irq
);

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         done_q, done_d;
    logic         irq_q, irq_d;
    logic         irq_set;
    logic         load_zero;

`ifdef AUTO_RELOAD_EN
    logic [W-1:0] reload_q, reload_d;
`endif

    assign load_zero = (load_val == '0);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            irq_q  <= irq_d;
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    // Next-state and datapath update; priority is stop > start > tick
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        irq_set = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!stop && start) begin
                    if (load_zero) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        irq_set = 1'b1;
                    end else begin
                        cnt_d   = load_val;
                        state_d = ST_RUN;
`ifdef AUTO_RELOAD_EN
                        reload_d = load_val;
`endif
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    if (load_zero) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        irq_set = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = load_val;
`ifdef AUTO_RELOAD_EN
                        reload_d = load_val;
`endif
                    end
                end else if (tick) begin
                    if (cnt_q > W'(1)) begin
                        cnt_d = cnt_q - W'(1);
                    end else if (cnt_q == W'(1)) begin
                        done_d  = 1'b1;
                        irq_set = 1'b1;
`ifdef AUTO_RELOAD_EN
                        cnt_d   = reload_q;
`else
                        cnt_d   = '0;
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A new expiry outranks a simultaneous clear
        irq_d = irq_set | (irq_q & ~irq_clr);
    end

    // Outputs: all come straight from registers
    always_comb begin
        busy = (state_q == ST_RUN);
        cnt  = cnt_q;
        done = done_q;
        irq  = irq_q;
    end

endmodule
